same_register_5bit: RTL and testbench

- Bitwise equality comparator for two 5-bit register specifiers, e.g. the source and destination fields of a register file.
- Produces a per-bit "same" vector, combinationally, as its primary result.
- Also produces whole-word match flags, including one that excludes register 0, as used by pipeline forwarding and hazard logic.
- Carries a registered copy of all results for use in the next pipeline stage.

---
 rtl/same_register_5bit.sv | 64 ++++++
 tb/tb_same_register_5bit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/same_register_5bit.sv
// Bitwise equality comparator for two register specifiers.
// Combinational results: per-bit "same" vector, whole-word match flag, and a
// match flag that ignores register 0 (which is hard-wired and never forwards).
// A registered copy of all three results feeds the next pipeline stage.
module same_register_5bit #(
  parameter int WIDTH = 5
) (
  output logic [WIDTH-1:0] same,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic             eq,
  output logic             eq_nz,
  output logic [WIDTH-1:0] same_r,
  output logic             eq_r,
  output logic             eq_nz_r
);

  logic [WIDTH-1:0] same_d, same_q;
  logic             eq_d, eq_q;
  logic             eq_nz_d, eq_nz_q;

  // Combinational compare: outputs track the inputs with no clock, reset or enable involvement.
  // NOTE: combinational blocks use blocking '=', and every output gets a value on every path, so no latch is inferred.
  always_comb begin
    same  = ~(inputA ^ inputB);
    eq    = &same;
    eq_nz = eq & (|inputA);
  end

  // Next-state selection: load fresh results when enabled, otherwise hold.
  always_comb begin
    same_d  = same_q;
    eq_d    = eq_q;
    eq_nz_d = eq_nz_q;
    if (en) begin
      same_d  = same;
      eq_d    = eq;
      eq_nz_d = eq_nz;
    end
  end

  // Pipeline registers; reset clears them to zero rather than to the
  // compare of whatever sits on the inputs while reset is held.
  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values; reset is asynchronous and wins over en.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      same_q  <= '0;
      eq_q    <= 1'b0;
      eq_nz_q <= 1'b0;
    end else begin
      same_q  <= same_d;
      eq_q    <= eq_d;
      eq_nz_q <= eq_nz_d;
    end
  end

  assign same_r  = same_q;
  assign eq_r    = eq_q;
  assign eq_nz_r = eq_nz_q;

endmodule

// File: tb/tb_same_register_5bit.sv
// Directed self-checking bench for same_register_5bit.
module tb_same_register_5bit;

  localparam int WIDTH = 5;

  logic [WIDTH-1:0] same, inputA, inputB, same_r;
  logic             clock, reset, en, eq, eq_nz, eq_r, eq_nz_r;

  int compared   = 0;
  int mismatched = 0;

  same_register_5bit #(.WIDTH(WIDTH)) dut (
    .same    (same),
    .inputA  (inputA),
    .inputB  (inputB),
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .eq      (eq),
    .eq_nz   (eq_nz),
    .same_r  (same_r),
    .eq_r    (eq_r),
    .eq_nz_r (eq_nz_r)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] a_v, b_v, exp_same;
    logic             exp_eq, exp_nz;

    // Reset held, enable high, both specifiers zero.
    reset  = 1'b1;
    en     = 1'b1;
    inputA = 5'b00000;
    inputB = 5'b00000;
    #1;
    check("rst_same_r_t0", same_r, 5'b00000);
    check("rst_eq_r_t0", {4'b0, eq_r}, 5'b00000);
    repeat (2) @(negedge clock);
    check("rst_same", same, 5'b11111);
    check("rst_eq", {4'b0, eq}, 5'b00001);
    check("rst_eq_nz", {4'b0, eq_nz}, 5'b00000);
    check("rst_same_r", same_r, 5'b00000);
    check("rst_eq_r", {4'b0, eq_r}, 5'b00000);
    check("rst_eq_nz_r", {4'b0, eq_nz_r}, 5'b00000);

    // Release reset, one capture edge.
    reset = 1'b0;
    @(posedge clock); #1;
    check("cap0_same_r", same_r, 5'b11111);
    check("cap0_eq_r", {4'b0, eq_r}, 5'b00001);
    check("cap0_eq_nz_r", {4'b0, eq_nz_r}, 5'b00000);

    // Exhaustive sweep: A counts every 20 ns, B every 640 ns.
    @(negedge clock);
    en = 1'b0;
    for (int b = 0; b < 32; b++) begin
      for (int a = 0; a < 32; a++) begin
        a_v = WIDTH'(a);
        b_v = WIDTH'(b);
        inputA = a_v;
        inputB = b_v;
        #1;
        exp_same = ~(a_v ^ b_v);
        exp_eq   = (a == b);
        exp_nz   = (a == b) && (a != 0);
        check("sweep_same", same, exp_same);
        check("sweep_eq", {4'b0, eq}, {4'b0, exp_eq});
        check("sweep_eq_nz", {4'b0, eq_nz}, {4'b0, exp_nz});
        #19;
      end
    end

    // Hand-computed spot checks.
    inputA = 5'b10101; inputB = 5'b10001; #1;
    check("spot1_same", same, 5'b11011);
    check("spot1_eq", {4'b0, eq}, 5'b00000);
    inputA = 5'b00111; inputB = 5'b00111; #1;
    check("spot2_same", same, 5'b11111);
    check("spot2_eq", {4'b0, eq}, 5'b00001);
    check("spot2_eq_nz", {4'b0, eq_nz}, 5'b00001);
    inputA = 5'b11111; inputB = 5'b11111; #1;
    check("ones_eq_nz", {4'b0, eq_nz}, 5'b00001);
    inputA = 5'b10110; inputB = 5'b01001; #1;
    check("inv_same", same, 5'b00000);
    check("inv_eq", {4'b0, eq}, 5'b00000);
    check("inv_eq_nz", {4'b0, eq_nz}, 5'b00000);

    // Hold check: capture 01010 == 01010, then freeze and disturb B.
    @(negedge clock);
    en = 1'b1; inputA = 5'b01010; inputB = 5'b01010;
    @(posedge clock); #1;
    check("hold_cap_same_r", same_r, 5'b11111);
    check("hold_cap_eq_r", {4'b0, eq_r}, 5'b00001);
    check("hold_cap_eq_nz_r", {4'b0, eq_nz_r}, 5'b00001);
    @(negedge clock);
    en = 1'b0; inputB = 5'b01011; #1;
    check("hold_same", same, 5'b11110);
    check("hold_eq", {4'b0, eq}, 5'b00000);
    repeat (3) @(posedge clock);
    #1;
    check("hold_same_r", same_r, 5'b11111);
    check("hold_eq_r", {4'b0, eq_r}, 5'b00001);
    check("hold_eq_nz_r", {4'b0, eq_nz_r}, 5'b00001);

    // Async reset between edges.
    @(negedge clock);
    reset = 1'b1; #1;
    check("arst_same_r", same_r, 5'b00000);
    check("arst_eq_r", {4'b0, eq_r}, 5'b00000);
    check("arst_eq_nz_r", {4'b0, eq_nz_r}, 5'b00000);
    check("arst_same", same, 5'b11110);
    check("arst_eq", {4'b0, eq}, 5'b00000);

    // Reset priority over enable at a clock edge.
    en = 1'b1; inputA = 5'b00111; inputB = 5'b00111;
    @(posedge clock); #1;
    check("prio_same_r", same_r, 5'b00000);
    check("prio_eq_r", {4'b0, eq_r}, 5'b00000);
    check("prio_eq_nz_r", {4'b0, eq_nz_r}, 5'b00000);

    // First edge after release captures normally.
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check("post_same_r", same_r, 5'b11111);
    check("post_eq_r", {4'b0, eq_r}, 5'b00001);
    check("post_eq_nz_r", {4'b0, eq_nz_r}, 5'b00001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
